// File: rtl/int_claim_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : int_claim_ctrl
// Brief   : CPU claim/complete front end for the interrupt controller's
//           per-source pending vector. Optional in-service watchdog is
//           enabled by defining INT_CLAIM_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
module int_claim_ctrl #(
   parameter int N              = 5,
   parameter int IDW            = 3,
   parameter int CLR_HOLD       = 3
`ifdef INT_CLAIM_TIMEOUT_EN
   , parameter int TIMEOUT_CYCLES = 1024
`endif
) (
   input  logic           clk_i,
   input  logic           reset_i,
   input  logic [N-1:0]   int_pending_i,
   output logic           cpu_irq_o,
   input  logic           claim_req_i,
   output logic           claim_ack_o,
   output logic           claim_valid_o,
   output logic [IDW-1:0] claim_id_o,
   input  logic           complete_req_i,
   input  logic [IDW-1:0] complete_id_i,
   output logic           complete_ack_o,
   output logic           complete_err_o,
   output logic [N-1:0]   int_clr_o,
   output logic           timeout_err_o
);
   localparam int            HW        = (CLR_HOLD > 1) ? $clog2(CLR_HOLD) : 1;
   localparam logic [HW-1:0] HOLD_LOAD = HW'(CLR_HOLD - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_CLAIMED = 2'd1,
      S_HOLD    = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [IDW-1:0] isr_id_q, isr_id_d;
   logic [HW-1:0]  hold_q, hold_d;
   logic [IDW-1:0] enc_id_q, enc_id_d;
   logic           enc_any_q, enc_any_d;
   logic           cpu_irq_q, cpu_irq_d;
   logic           claim_ack_q, claim_ack_d;
   logic           claim_valid_q, claim_valid_d;
   logic [IDW-1:0] claim_id_q, claim_id_d;
   logic           complete_ack_q, complete_ack_d;
   logic           complete_err_q, complete_err_d;
   logic [N-1:0]   int_clr_q, int_clr_d;
   logic           complete_hit;
   logic           timeout_hit;

   // Lowest index wins; the result is registered, so a claim selects from
   // the pending vector as it stood on the previous clock.
   always_comb begin
      enc_id_d  = '0;
      enc_any_d = |int_pending_i;
      for (int i = N - 1; i >= 0; i--) begin
         if (int_pending_i[i]) enc_id_d = IDW'(i);
      end
   end

   // Out-of-range IDs can never equal isr_id, so they always mismatch.
   assign complete_hit = complete_req_i && (complete_id_i == isr_id_q);

   always_comb begin
      state_d        = state_q;
      isr_id_d       = isr_id_q;
      hold_d         = hold_q;
      claim_ack_d    = claim_req_i;
      claim_valid_d  = 1'b0;
      claim_id_d     = '0;
      complete_ack_d = complete_req_i;
      complete_err_d = complete_req_i;
      int_clr_d      = '0;
      case (state_q)
         S_IDLE: begin
            if (claim_req_i && !complete_req_i && enc_any_q) begin
               claim_valid_d = 1'b1;
               claim_id_d    = enc_id_q;
               isr_id_d      = enc_id_q;
               state_d       = S_CLAIMED;
            end
         end
         S_CLAIMED: begin
            claim_id_d = isr_id_q;
            if (complete_hit || timeout_hit) begin
               int_clr_d = N'(1) << isr_id_q;
               hold_d    = HOLD_LOAD;
               state_d   = S_HOLD;
            end
            if (complete_hit) complete_err_d = 1'b0;
         end
         S_HOLD: begin
            if (hold_q == '0) state_d = S_IDLE;
            else              hold_d  = hold_q - HW'(1);
         end
         default: state_d = S_IDLE;
      endcase
      cpu_irq_d = (state_d == S_IDLE) && enc_any_d;
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q        <= S_IDLE;
         isr_id_q       <= '0;
         hold_q         <= '0;
         enc_id_q       <= '0;
         enc_any_q      <= 1'b0;
         cpu_irq_q      <= 1'b0;
         claim_ack_q    <= 1'b0;
         claim_valid_q  <= 1'b0;
         claim_id_q     <= '0;
         complete_ack_q <= 1'b0;
         complete_err_q <= 1'b0;
         int_clr_q      <= '0;
      end else begin
         state_q        <= state_d;
         isr_id_q       <= isr_id_d;
         hold_q         <= hold_d;
         enc_id_q       <= enc_id_d;
         enc_any_q      <= enc_any_d;
         cpu_irq_q      <= cpu_irq_d;
         claim_ack_q    <= claim_ack_d;
         claim_valid_q  <= claim_valid_d;
         claim_id_q     <= claim_id_d;
         complete_ack_q <= complete_ack_d;
         complete_err_q <= complete_err_d;
         int_clr_q      <= int_clr_d;
      end
   end

`ifdef INT_CLAIM_TIMEOUT_EN
   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [TW-1:0] tcnt_q, tcnt_d;
   logic          timeout_q, timeout_d;

   // A valid completion on the final watchdog cycle takes precedence.
   always_comb begin
      timeout_hit = (state_q == S_CLAIMED) && !complete_hit &&
                    (tcnt_q == TW'(TIMEOUT_CYCLES - 1));
      tcnt_d      = ((state_q == S_CLAIMED) && !complete_hit && !timeout_hit) ?
                    tcnt_q + TW'(1) : '0;
      timeout_d   = timeout_q | timeout_hit;
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         tcnt_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         tcnt_q    <= tcnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign timeout_err_o = timeout_q;
`else
   assign timeout_hit   = 1'b0;
   assign timeout_err_o = 1'b0;
`endif

   assign cpu_irq_o      = cpu_irq_q;
   assign claim_ack_o    = claim_ack_q;
   assign claim_valid_o  = claim_valid_q;
   assign claim_id_o     = claim_id_q;
   assign complete_ack_o = complete_ack_q;
   assign complete_err_o = complete_err_q;
   assign int_clr_o      = int_clr_q;
endmodule
`default_nettype wire

// File: doc/int_claim_ctrl.md
# int_claim_ctrl

CPU-facing claim/complete unit for the interrupt controller's per-source `int_state` vector.
- Presents a single CPU interrupt request.
- On a CPU claim, returns the highest-priority pending source ID and tracks it as in-service.
- On completion, pulses that source's `int_clr` back to the controller.
- Runs in the controller's clock domain, between the controller and the CPU bus glue.

## Interface
- `N`, 5: number of interrupt sources.
- `IDW`, 3: ID width; must satisfy 2^IDW >= N.
- `CLR_HOLD`, 3: hold-off cycles after a clear pulse, covering the controller's state/valid pipeline.
- `TIMEOUT_CYCLES`, 1024: in-service watchdog limit. Used only with `INT_CLAIM_TIMEOUT_EN`.

Ports:
- `clk` in 1: clock, shared with the controller.
- `reset` in 1: asynchronous, active-high reset.
- `int_pending` in N: per-source `int_state` from the controller.
- `cpu_irq` out 1: interrupt request to the CPU.
- `claim_req` in 1: single-cycle claim strobe.
- `claim_ack` out 1: claim response strobe.
- `claim_valid` out 1: qualifies `claim_id` during `claim_ack`.
- `claim_id` out IDW: claimed source index.
- `complete_req` in 1: single-cycle completion strobe.
- `complete_id` in IDW: ID being completed.
- `complete_ack` out 1: completion response strobe.
- `complete_err` out 1: ID mismatch or no source in service; valid during `complete_ack`.
- `int_clr` out N: one-cycle clear pulses to the controller.
- `timeout_err` out 1: sticky watchdog flag (`INT_CLAIM_TIMEOUT_EN` only).

## Operation
- Priority is fixed: lowest index wins. Selection uses a registered priority encoder over `int_pending`.
- FSM states: IDLE, CLAIMED, HOLD.
  - **IDLE**
    - `cpu_irq` = |`int_pending`.
    - On `claim_req` with any source pending: latch the winner into `isr_id`, respond `claim_valid`=1 with that ID, go to CLAIMED.
    - On `claim_req` with nothing pending: respond `claim_valid`=0, `claim_id`=0, stay in IDLE.
  - **CLAIMED**
    - `cpu_irq` = 0. Nesting is not supported.
    - A further `claim_req` gets `claim_valid`=0, `claim_id`=`isr_id`.
    - On `complete_req` with `complete_id`==`isr_id`: pulse `int_clr[isr_id]`, respond `complete_err`=0, go to HOLD.
    - On `complete_req` with a mismatched ID: respond `complete_err`=1, stay in CLAIMED, no clear.
  - **HOLD**
    - `cpu_irq` = 0; a down-counter runs `CLR_HOLD` cycles, then the FSM returns to IDLE.
    - Claims in HOLD respond `claim_valid`=0.
- `complete_req` in IDLE or HOLD responds `complete_err`=1 with no clear.
- Level-triggered sources still asserted re-raise `cpu_irq` after HOLD. This is intended: the source must be serviced at the device.
- `claim_req` and `complete_req` in the same cycle: completion is processed first, and the claim responds `claim_valid`=0.
- Out-of-range claimed IDs (index >= N) cannot occur. Out-of-range `complete_id` values always mismatch.

## Timing
- Reset values:
  - State IDLE; `isr_id`=0; hold counter 0.
  - Outputs `cpu_irq`, `claim_ack`, `claim_valid`, `claim_id`, `complete_ack`, `complete_err`, `int_clr`, `timeout_err` all 0.
- `cpu_irq` is registered: it asserts 1 cycle after `int_pending` rises while in IDLE.
- `claim_ack` and its data are asserted exactly 1 cycle after `claim_req`, for 1 cycle.
- `complete_ack` and `int_clr` pulse together, 1 cycle after `complete_req`, for 1 cycle.
- The HOLD counter starts the cycle `int_clr` is high. IDLE is re-entered `CLR_HOLD` cycles later.
- Asserting `reset` mid-operation drops all outputs within the same cycle (async) and discards in-service state. No `int_clr` is issued.

## Configuration
- `INT_CLAIM_TIMEOUT_EN` defined:
  - A cycle counter runs while in CLAIMED.
  - When the counter reaches `TIMEOUT_CYCLES`, the block auto-completes: pulses `int_clr[isr_id]`, sets `timeout_err`, enters HOLD. No `complete_ack` is issued.
  - `timeout_err` is cleared only by `reset`.
- `INT_CLAIM_TIMEOUT_EN` undefined: no counter; `timeout_err` is tied to 0. CLAIMED persists until a valid completion.

## Test plan
- Reset release, `int_pending`=5'b10100, claim: `cpu_irq`=1 one cycle later; `claim_ack`, `claim_valid`=1, `claim_id`=2 one cycle after the strobe.
- Complete ID 2: `int_clr`=5'b00100 for 1 cycle with `complete_ack`, `complete_err`=0. After `CLR_HOLD`=3 cycles, `cpu_irq` re-asserts for source 4.
- In CLAIMED, complete ID 3: `complete_err`=1, `int_clr`=0, state unchanged. A second claim returns `claim_valid`=0.
- Claim with `int_pending`=0: `claim_ack`=1, `claim_valid`=0, `claim_id`=0. Same-cycle claim and complete: clear issued, claim invalid.
- Reset pulsed while in CLAIMED: all outputs 0 immediately, and no `int_clr` is issued afterwards.
- With `INT_CLAIM_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16, claim source 0 and never complete: `int_clr[0]` pulses 16 cycles after the claim and `timeout_err` stays 1.
